// File: rtl/ram_arb.sv
// Two-requester arbiter sharing one single-port RAM between the host loader and the CPU.
// Grants are decided combinationally each cycle; read data returns to the winner one cycle later.
module ram_arb #(
    parameter int unsigned XLEN      = 32,
    parameter bit          HOST_PRIO = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            host_lock_i,
    // host loader port
    input  logic            h_req_i,
    input  logic            h_we_i,
    input  logic [XLEN-1:0] h_addr_i,
    input  logic [XLEN-1:0] h_wdata_i,
    input  logic [3:0]      h_byte_en_i,
    output logic            h_gnt_o,
    output logic [XLEN-1:0] h_rdata_o,
    output logic            h_rvld_o,
    // CPU data port
    input  logic            c_req_i,
    input  logic            c_we_i,
    input  logic [XLEN-1:0] c_addr_i,
    input  logic [XLEN-1:0] c_wdata_i,
    input  logic [3:0]      c_byte_en_i,
    output logic            c_gnt_o,
    output logic [XLEN-1:0] c_rdata_o,
    output logic            c_rvld_o,
    // RAM port
    output logic            mem_en_o,
    output logic [3:0]      mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i
);

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_CPU  = 1'b1
    } owner_e;

    owner_e          last_q;
    logic            h_pend_q;
    logic            c_pend_q;
    logic [XLEN-1:0] h_rdata_q;
    logic [XLEN-1:0] c_rdata_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic            h_elig_c;
    logic            c_elig_c;
    logic            h_win_c;
    logic            c_win_c;

    // Arbitration: lock masks the CPU, conflicts go to the host or to whoever did not win last
    always_comb begin
        h_elig_c = h_req_i & ~rst_i;
        c_elig_c = c_req_i & ~host_lock_i & ~rst_i;
        h_win_c  = h_elig_c & (~c_elig_c | HOST_PRIO | (last_q == OWN_CPU));
        c_win_c  = c_elig_c & ~h_win_c;
    end

    // RAM port mux; address and write data hold their last driven value when idle
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 4'b0000;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (h_win_c) begin
            mem_en_o    = 1'b1;
            mem_we_o    = h_we_i ? h_byte_en_i : 4'b0000;
            mem_addr_o  = h_addr_i;
            mem_wdata_o = h_wdata_i;
        end else if (c_win_c) begin
            mem_en_o    = 1'b1;
            mem_we_o    = c_we_i ? c_byte_en_i : 4'b0000;
            mem_addr_o  = c_addr_i;
            mem_wdata_o = c_wdata_i;
        end
    end

    // Grant outputs and read return; a pending return is suppressed while reset is asserted
    always_comb begin
        h_gnt_o   = h_win_c;
        c_gnt_o   = c_win_c;
        h_rvld_o  = h_pend_q & ~rst_i;
        c_rvld_o  = c_pend_q & ~rst_i;
        h_rdata_o = h_rvld_o ? mem_rdata_i : h_rdata_q;
        c_rdata_o = c_rvld_o ? mem_rdata_i : c_rdata_q;
    end

    // Last winner, read-pending owner, held read data and held RAM address/data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q    <= OWN_CPU;
            h_pend_q  <= 1'b0;
            c_pend_q  <= 1'b0;
            h_rdata_q <= '0;
            c_rdata_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            if (h_win_c || c_win_c) begin
                last_q  <= h_win_c ? OWN_HOST : OWN_CPU;
                addr_q  <= mem_addr_o;
                wdata_q <= mem_wdata_o;
            end
            h_pend_q <= h_win_c & ~h_we_i;
            c_pend_q <= c_win_c & ~c_we_i;
            if (h_pend_q) begin
                h_rdata_q <= mem_rdata_i;
            end
            if (c_pend_q) begin
                c_rdata_q <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: a round-robin instance (index 0) and a host-priority instance (index 1)
// share one stimulus stream; each drives its own RAM and is checked against a word-level model.
module tb_ram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        lock;
    logic        h_req, h_we, c_req, c_we;
    logic [31:0] h_addr, h_wdata, c_addr, c_wdata;
    logic [3:0]  h_be, c_be;

    logic        h_gnt [2];
    logic        c_gnt [2];
    logic        h_rvld[2];
    logic        c_rvld[2];
    logic        mem_en[2];
    logic [3:0]  mem_we[2];
    logic [31:0] h_rdata[2];
    logic [31:0] c_rdata[2];
    logic [31:0] mem_addr[2];
    logic [31:0] mem_wdata[2];
    logic [31:0] mem_rdata[2];

    logic [31:0] ram[2][64];

    // reference model state
    bit          host_turn[2];
    logic [31:0] shadow[2][64];
    bit          hp_pend[2];
    bit          cp_pend[2];
    logic [31:0] h_val[2];
    logic [31:0] c_val[2];
    logic [31:0] h_held[2];
    logic [31:0] c_held[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wdata[2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_arb #(.XLEN(32), .HOST_PRIO(1'b0)) u_rr (
        .clk_i(clk), .rst_i(rst), .host_lock_i(lock),
        .h_req_i(h_req), .h_we_i(h_we), .h_addr_i(h_addr), .h_wdata_i(h_wdata), .h_byte_en_i(h_be),
        .h_gnt_o(h_gnt[0]), .h_rdata_o(h_rdata[0]), .h_rvld_o(h_rvld[0]),
        .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata), .c_byte_en_i(c_be),
        .c_gnt_o(c_gnt[0]), .c_rdata_o(c_rdata[0]), .c_rvld_o(c_rvld[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
        .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0])
    );

    ram_arb #(.XLEN(32), .HOST_PRIO(1'b1)) u_hp (
        .clk_i(clk), .rst_i(rst), .host_lock_i(lock),
        .h_req_i(h_req), .h_we_i(h_we), .h_addr_i(h_addr), .h_wdata_i(h_wdata), .h_byte_en_i(h_be),
        .h_gnt_o(h_gnt[1]), .h_rdata_o(h_rdata[1]), .h_rvld_o(h_rvld[1]),
        .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata), .c_byte_en_i(c_be),
        .c_gnt_o(c_gnt[1]), .c_rdata_o(c_rdata[1]), .c_rvld_o(c_rvld[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
        .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1])
    );

    // Synchronous RAM per instance: byte writes, read data one cycle after a read strobe
    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (mem_en[p]) begin
                if (mem_we[p] != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_we[p][b]) ram[p][mem_addr[p][7:2]][8*b +: 8] <= mem_wdata[p][8*b +: 8];
                end else begin
                    mem_rdata[p] <= ram[p][mem_addr[p][7:2]];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic set_h(input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        h_req = req; h_we = we; h_addr = a; h_wdata = d; h_be = be;
    endtask

    task automatic set_c(input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        c_req = req; c_we = we; c_addr = a; c_wdata = d; c_be = be;
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            host_turn[p] = 1'b1;
            hp_pend[p] = 1'b0;  cp_pend[p] = 1'b0;
            h_held[p] = '0;     c_held[p] = '0;
            m_addr[p] = '0;     m_wdata[p] = '0;
        end
    endtask

    // One clock cycle: check all outputs against the model, then advance the model at the edge
    task automatic cycle();
        bit          he, ce, wh, wc, ev;
        logic [31:0] a, d;
        logic [3:0]  ewe;
        bit          wh_s[2];
        bit          wc_s[2];
        bit          rst_s;
        #1;
        for (int p = 0; p < 2; p++) begin
            he = h_req && !rst;
            ce = c_req && !lock && !rst;
            if (he && ce) wh = (p == 1) ? 1'b1 : host_turn[p];
            else          wh = he;
            wc = ce && !wh;
            wh_s[p] = wh;  wc_s[p] = wc;
            a   = wh ? h_addr  : (wc ? c_addr  : m_addr[p]);
            d   = wh ? h_wdata : (wc ? c_wdata : m_wdata[p]);
            ewe = wh ? (h_we ? h_be : 4'b0000) : (wc ? (c_we ? c_be : 4'b0000) : 4'b0000);
            chk($sformatf("p%0d h_gnt", p), 32'(h_gnt[p]), 32'(wh));
            chk($sformatf("p%0d c_gnt", p), 32'(c_gnt[p]), 32'(wc));
            chk($sformatf("p%0d mem_en", p), 32'(mem_en[p]), 32'(wh || wc));
            chk($sformatf("p%0d mem_we", p), 32'(mem_we[p]), 32'(ewe));
            chk($sformatf("p%0d mem_addr", p), mem_addr[p], a);
            chk($sformatf("p%0d mem_wdata", p), mem_wdata[p], d);
            ev = hp_pend[p] && !rst;
            chk($sformatf("p%0d h_rvld", p), 32'(h_rvld[p]), 32'(ev));
            chk($sformatf("p%0d h_rdata", p), h_rdata[p], ev ? h_val[p] : h_held[p]);
            ev = cp_pend[p] && !rst;
            chk($sformatf("p%0d c_rvld", p), 32'(c_rvld[p]), 32'(ev));
            chk($sformatf("p%0d c_rdata", p), c_rdata[p], ev ? c_val[p] : c_held[p]);
        end
        @(posedge clk);
        rst_s = rst;
        if (rst_s) begin
            model_reset();
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (hp_pend[p]) h_held[p] = h_val[p];
                if (cp_pend[p]) c_held[p] = c_val[p];
                hp_pend[p] = 1'b0;
                cp_pend[p] = 1'b0;
                if (wh_s[p] || wc_s[p]) begin
                    host_turn[p] = wc_s[p];
                    m_addr[p]    = wh_s[p] ? h_addr  : c_addr;
                    m_wdata[p]   = wh_s[p] ? h_wdata : c_wdata;
                    if (wh_s[p] ? h_we : c_we) begin
                        for (int b = 0; b < 4; b++)
                            if (wh_s[p] ? h_be[b] : c_be[b])
                                shadow[p][m_addr[p][7:2]][8*b +: 8] = m_wdata[p][8*b +: 8];
                    end else if (wh_s[p]) begin
                        hp_pend[p] = 1'b1;
                        h_val[p]   = shadow[p][m_addr[p][7:2]];
                    end else begin
                        cp_pend[p] = 1'b1;
                        c_val[p]   = shadow[p][m_addr[p][7:2]];
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 64; i++) begin
                ram[p][i] = '0;
                shadow[p][i] = '0;
            end
        rst = 1'b1; lock = 1'b0;
        set_h(0, 0, '0, '0, '0);
        set_c(0, 0, '0, '0, '0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        model_reset();

        // reset state
        cycle();
        chk("reset mem_en", 32'(mem_en[0]), 32'd0);
        chk("reset mem_addr", mem_addr[0], 32'd0);
        rst = 1'b0;

        // host write
        set_h(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("wr h_gnt", 32'(h_gnt[0]), 32'd1);
        chk("wr mem_we", 32'(mem_we[0]), 32'hF);
        chk("wr mem_addr", mem_addr[0], 32'h10);
        cycle();
        set_h(0, 0, 32'h10, '0, '0);
        chk("wr no h_rvld", 32'(h_rvld[0]), 32'd0);
        cycle();

        // host read
        set_h(1, 0, 32'h10, '0, '0);
        cycle();
        set_h(0, 0, 32'h10, '0, '0);
        chk("rd h_rvld", 32'(h_rvld[0]), 32'd1);
        chk("rd h_rdata", h_rdata[0], 32'hDEAD_BEEF);
        chk("rd c_rvld", 32'(c_rvld[0]), 32'd0);
        cycle();
        chk("rd h_rvld drop", 32'(h_rvld[0]), 32'd0);
        chk("rd h_rdata hold", h_rdata[0], 32'hDEAD_BEEF);

        // CPU partial write, then a write with no byte enables
        set_c(1, 1, 32'h20, 32'h1234_5678, 4'b0011);
        cycle();
        set_c(1, 1, 32'h24, 32'hFFFF_FFFF, 4'b0000);
        #1;
        chk("be0 c_gnt", 32'(c_gnt[0]), 32'd1);
        chk("be0 mem_en", 32'(mem_en[0]), 32'd1);
        chk("be0 mem_we", 32'(mem_we[0]), 32'd0);
        cycle();
        set_c(0, 0, 32'h24, '0, '0);
        cycle();

        // fresh reset, then round-robin / host-priority conflict
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_h(1, 0, 32'h10, '0, '0);
        set_c(1, 0, 32'h20, '0, '0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rr h_gnt %0d", i), 32'(h_gnt[0]), 32'((i % 2) == 0));
            chk($sformatf("rr c_gnt %0d", i), 32'(c_gnt[0]), 32'((i % 2) == 1));
            chk($sformatf("hp h_gnt %0d", i), 32'(h_gnt[1]), 32'd1);
            chk($sformatf("hp c_gnt %0d", i), 32'(c_gnt[1]), 32'd0);
            cycle();
        end
        set_h(0, 0, 32'h10, '0, '0);
        #1;
        chk("hp c_gnt after h drop", 32'(c_gnt[1]), 32'd1);
        cycle();
        set_c(0, 0, 32'h20, '0, '0);
        cycle();

        // host lock holds the CPU off
        lock = 1'b1;
        set_c(1, 0, 32'h20, '0, '0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("lock c_gnt %0d", i), 32'(c_gnt[0]), 32'd0);
            chk($sformatf("lock mem_en %0d", i), 32'(mem_en[0]), 32'd0);
            cycle();
        end
        lock = 1'b0;
        #1;
        chk("unlock c_gnt rr", 32'(c_gnt[0]), 32'd1);
        chk("unlock c_gnt hp", 32'(c_gnt[1]), 32'd1);
        cycle();
        set_c(0, 0, 32'h20, '0, '0);
        cycle();

        // reset right after a granted CPU read
        set_c(1, 0, 32'h20, '0, '0);
        #1;
        chk("rstrd c_gnt", 32'(c_gnt[0]), 32'd1);
        rst = 1'b1;
        set_c(0, 0, 32'h20, '0, '0);
        cycle();
        chk("rstrd c_rvld", 32'(c_rvld[0]), 32'd0);
        chk("rstrd mem_en", 32'(mem_en[0]), 32'd0);
        chk("rstrd c_rdata", c_rdata[0], 32'd0);
        cycle();
        rst = 1'b0;
        set_h(1, 0, 32'h10, '0, '0);
        set_c(1, 0, 32'h20, '0, '0);
        #1;
        chk("post-rst h wins", 32'(h_gnt[0]), 32'd1);
        chk("post-rst c waits", 32'(c_gnt[0]), 32'd0);
        cycle();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(63) == 0);
            lock = ($urandom_range(4) == 0);
            set_h(1'($urandom_range(1)), 1'($urandom_range(1)), 32'($urandom_range(15)) << 2,
                  $urandom, 4'($urandom_range(15)));
            set_c(1'($urandom_range(1)), 1'($urandom_range(1)), 32'($urandom_range(15)) << 2,
                  $urandom, 4'($urandom_range(15)));
            cycle();
        end
        rst = 1'b0; lock = 1'b0;
        set_h(0, 0, '0, '0, '0);
        set_c(0, 0, '0, '0, '0);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
